mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file: consumes ReadData1/ReadData2 as OperandA/OperandB in EX for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Hi/Lo feed the MFHI/MFLO result path back toward the register-file write port.
- Busy stalls the pipeline controller until Done.

Parameters:
- XLEN, 32, operand/result width; HI and LO are each XLEN bits.
- CNT_W, 6, iteration counter width; must hold XLEN+1.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request a new operation; sampled only in IDLE.
- Op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with Start.
- OperandA  input  XLEN  rs value: multiplicand or dividend.
- OperandB  input  XLEN  rt value: multiplier or divisor.
- MtHi  input  1  write OperandA into HI.
- MtLo  input  1  write OperandA into LO.
- Hi  output  XLEN  HI register.
- Lo  output  XLEN  LO register.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when Hi/Lo take a new result.

Behaviour:
- Reset: asynchronous and active-low. Assertion forces state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0.
- Reset mid-operation aborts the operation; no partial result ever appears on Hi/Lo.
- States: IDLE, RUN, FIX.
- IDLE + Start at edge E0:
  - Latch abs(A) and abs(B); abs is applied only for signed ops.
  - Latch result sign and remainder sign; clear the accumulator.
  - Set counter=XLEN, go to RUN, Busy=1.
- RUN, one iteration per edge (E1..E32), counter decrements each edge:
  - Multiply: shift-add, 2*XLEN-bit product.
  - Divide: restoring; quotient in Lo side, remainder in Hi side.
  - counter==1 at an edge -> go to FIX.
- FIX (edge E33):
  - Negate product, quotient or remainder as required.
  - Write Hi/Lo, pulse Done=1, set Busy=0, go to IDLE.
  - Result first visible after E33.
- Signed arithmetic:
  - Product is the full 64-bit two's complement value.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - -2^31 / -1 -> Lo=0x80000000, Hi=0.
- Divide by zero (DIV or DIVU with B=0):
  - No RUN state.
  - At E1: Hi=OperandA (as latched), Lo=0xFFFFFFFF, Done pulses.
  - Busy is high for exactly one cycle.
- Start while Busy: ignored, no queuing. The latched operands are unaffected.
- MtHi/MtLo:
  - Honoured only in IDLE with Start=0; take effect at the next edge.
  - Both together write OperandA to HI and LO.
  - Ignored while Busy.
  - In the same cycle as Start, Start wins and the Mt* request is dropped.
- Done is never asserted for MtHi/MtLo writes.
- Hi/Lo hold their value between writes. No combinational path exists from Start to Busy (Busy is registered).

Optional Feature:
- Macro: MULT_DIV_EARLY_EXIT_EN.
- Defined (multiply ops only): RUN exits to FIX after the first iteration that leaves the remaining shifted multiplier equal to zero. Minimum is one iteration. Latency becomes max(1, bitlength(|B|)) + 1 edges. Divide is unchanged.
- Undefined: every multiply takes exactly XLEN RUN iterations; Done after E33.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> after E33: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Done high one cycle, Busy low.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001 after E33.
- DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 -> at E1: Hi=0x1234, Lo=0xFFFFFFFF, Busy high one cycle. Then MtLo with A=5 -> Lo=5, Done stays 0.
- Start a MULTU 3*4; re-pulse Start with different operands at E10; assert Rst_n=0 at E20 on a second run -> first run yields Lo=12 (second Start ignored); reset run ends with Hi=Lo=0, Busy=0, Done never pulses.
- With MULT_DIV_EARLY_EXIT_EN: MULTU 5*3 -> Done after E3, Lo=15. MULTU 5*0 -> Done after E2, Lo=0. Without the macro, both complete after E33.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit holding the architectural
// HI/LO registers of the MIPS datapath.
//
// Multiply is shift-add on magnitudes. Divide is restoring on magnitudes.
// The sign is fixed up in a final FIX cycle. A start in IDLE takes XLEN RUN
// edges plus one FIX edge. Divide by zero goes straight to FIX and finishes
// after one edge.
//
// Optional feature: define MULT_DIV_EARLY_EXIT_EN to leave RUN as soon as
// the remaining multiplier bits are all zero. This applies to multiply only.
//
// Ports:
//   Clk       rising-edge clock
//   Rst_n     asynchronous active-low reset
//   Start     start an operation (sampled only in IDLE)
//   Op        00=MULT 01=MULTU 10=DIV 11=DIVU (sampled with Start)
//   OperandA  rs: multiplicand / dividend; MTHI/MTLO data
//   OperandB  rt: multiplier / divisor
//   MtHi/MtLo write OperandA into HI/LO (IDLE, no Start)
//   Hi, Lo    architectural HI/LO
//   Busy      operation in progress (registered)
//   Done      one-cycle pulse when Hi/Lo take a new result
module mult_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] OperandA,
  input  logic [XLEN-1:0] OperandB,
  input  logic            MtHi,
  input  logic            MtLo,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo,
  output logic            Busy,
  output logic            Done
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_q, state_d;
  // acc: product for multiply; {remainder, quotient/dividend} for divide.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  // mcd: left-shifting multiplicand, or the divisor in the low half.
  logic [2*XLEN-1:0]   mcd_q, mcd_d;
  // mlr: right-shifting multiplier.
  logic [XLEN-1:0]     mlr_q, mlr_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                divz_q, divz_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                sgn;
  logic [XLEN-1:0]     abs_a, abs_b, mlr_sh;
  logic [XLEN:0]       shl, trial;
  logic [2*XLEN-1:0]   prod_neg;
  logic [XLEN-1:0]     quo_neg, rem_neg;
  logic                last_iter;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcd_d     = mcd_q;
    mlr_d     = mlr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    divz_d    = divz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    last_iter = 1'b0;

    sgn   = ~Op[0];
    abs_a = (sgn && OperandA[XLEN-1]) ? -OperandA : OperandA;
    abs_b = (sgn && OperandB[XLEN-1]) ? -OperandB : OperandB;

    // Restoring step: shift the partial remainder left by one bit, pulling in
    // the next dividend bit. Subtract the divisor only when it fits. The
    // remainder is always below the divisor, so a borrow shows up as the MSB
    // of trial.
    shl    = acc_q[2*XLEN-1:XLEN-1];
    trial  = shl - {1'b0, mcd_q[XLEN-1:0]};
    mlr_sh = mlr_q >> 1;

    prod_neg = -acc_q;
    quo_neg  = -acc_q[XLEN-1:0];
    rem_neg  = -acc_q[2*XLEN-1:XLEN];

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          is_div_d  = Op[1];
          neg_res_d = sgn & (OperandA[XLEN-1] ^ OperandB[XLEN-1]);
          neg_rem_d = sgn & OperandA[XLEN-1];
          busy_d    = 1'b1;
          cnt_d     = CNT_W'(XLEN);
          divz_d    = 1'b0;
          state_d   = RUN;
          if (Op[1]) begin
            mcd_d = {{XLEN{1'b0}}, abs_b};
            if (OperandB == '0) begin
              // Keep the raw dividend; it becomes HI.
              divz_d  = 1'b1;
              acc_d   = {OperandA, {XLEN{1'b0}}};
              state_d = FIX;
            end else begin
              acc_d = {{XLEN{1'b0}}, abs_a};
            end
          end else begin
            acc_d = '0;
            mcd_d = {{XLEN{1'b0}}, abs_a};
            mlr_d = abs_b;
          end
        end else begin
          if (MtHi) hi_d = OperandA;
          if (MtLo) lo_d = OperandA;
        end
      end

      RUN: begin
        cnt_d     = cnt_q - 1'b1;
        last_iter = (cnt_q == CNT_W'(1));
        if (is_div_q) begin
          if (!trial[XLEN]) acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else              acc_d = {shl[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
        end else begin
          if (mlr_q[0]) acc_d = acc_q + mcd_q;
          mcd_d = mcd_q << 1;
          mlr_d = mlr_sh;
`ifdef MULT_DIV_EARLY_EXIT_EN
          // No multiplier bits left, so the product is already complete.
          if (mlr_sh == '0) last_iter = 1'b1;
`endif
        end
        if (last_iter) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (divz_q) begin
          hi_d = acc_q[2*XLEN-1:XLEN];
          lo_d = '1;
        end else if (is_div_q) begin
          lo_d = neg_res_q ? quo_neg : acc_q[XLEN-1:0];
          hi_d = neg_rem_q ? rem_neg : acc_q[2*XLEN-1:XLEN];
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcd_q     <= '0;
      mlr_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      divz_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcd_q     <= mcd_d;
      mlr_q     <= mlr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      divz_q    <= divz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Rst_n, Start, MtHi, MtLo;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int ncmp = 0;
  int nfail = 0;
  logic [31:0] mhi = '0, mlo = '0;   // model of HI/LO

  mult_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .MtHi(MtHi), .MtLo(MtLo),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {HI, LO}, computed with plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Count of edges after the start edge until Done is visible.
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] mag;
    int bl;
    if (op[1]) return (b == 0) ? 1 : 33;
    mag = (op == 2'd0 && b[31]) ? -b : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
`ifdef MULT_DIV_EARLY_EXIT_EN
    return ((bl < 1) ? 1 : bl) + 1;
`else
    return 33;
`endif
  endfunction

  // noise: randomly wiggle inputs while the unit is busy; these must be ignored.
  // repulse: if non-zero, re-assert Start with other operands at that edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input int repulse, input string tag);
    logic [63:0] exp;
    int lat, n;
    bit hold_ok, extra_done;
    exp = ref_res(op, a, b);
    lat = ref_lat(op, b);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    MtHi = noise ? 1'($urandom) : 1'b0;
    MtLo = noise ? 1'($urandom) : 1'b0;
    #1;
    chk({tag, " busy_not_comb"}, {63'd0, Busy}, 64'd0);
    @(posedge Clk); #1;
    chk({tag, " busy_after_start"}, {63'd0, Busy}, 64'd1);
    n = 0; hold_ok = 1'b1;
    while (!Done && n < 60) begin
      Start = (repulse != 0 && n == repulse - 1) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      if (repulse != 0 && n == repulse - 1) begin
        OperandA = 32'd7; OperandB = 32'd9;
      end else if (noise) begin
        OperandA = $urandom; OperandB = $urandom; Op = 2'($urandom);
      end
      MtHi = noise ? 1'($urandom) : 1'b0;
      MtLo = noise ? 1'($urandom) : 1'b0;
      @(posedge Clk); #1;
      n++;
      if (!Done && ({Hi, Lo} !== {mhi, mlo})) hold_ok = 1'b0;
    end
    Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " hilo"}, {Hi, Lo}, exp);
    chk({tag, " busy_at_done"}, {63'd0, Busy}, 64'd0);
    chk({tag, " hold_during_run"}, {63'd0, hold_ok}, 64'd1);
    mhi = exp[63:32]; mlo = exp[31:0];
    @(posedge Clk); #1;
    extra_done = Done;
    chk({tag, " done_one_cycle"}, {63'd0, extra_done}, 64'd0);
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] a, input string tag);
    MtHi = h; MtLo = l; OperandA = a; Start = 1'b0;
    @(posedge Clk); #1;
    MtHi = 1'b0; MtLo = 1'b0;
    if (h) mhi = a;
    if (l) mlo = a;
    chk({tag, " hilo"}, {Hi, Lo}, {mhi, mlo});
    chk({tag, " no_done"}, {62'd0, Done, Busy}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 20));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen_done, seen_busy;
    Rst_n = 1'b0; Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0; Op = 2'd0;
    OperandA = '0; OperandB = '0;
    #12;
    chk("reset state", {Hi, Lo, 30'd0, Busy, Done}, 96'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Directed cases
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, "mult_neg3x7");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg7_2");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    run_op(2'd3, 32'h0000_1234, 32'd0, 0, 0, "divu_by0");
    mt(0, 1, 32'd5, "mtlo5");
    mt(1, 0, 32'hCAFE_0001, "mthi");
    mt(1, 1, 32'h1357_9BDF, "mthilo");
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0, 0, "div_neg_by0");
    run_op(2'd1, 32'd5, 32'd3, 0, 0, "multu_5x3");
    run_op(2'd1, 32'd5, 32'd0, 0, 0, "multu_5x0");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, "mult_minmin");

    // Start re-pulsed mid-run is ignored
    run_op(2'd1, 32'd3, 32'd4, 0, 10, "multu_repulse");

    // Reset in the middle of a second run
    Op = 2'd1; OperandA = 32'd3; OperandB = 32'd4; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (19) begin @(posedge Clk); #1; end
    Rst_n = 1'b0;
    #1;
    chk("midrun_reset hilo", {Hi, Lo}, 64'd0);
    chk("midrun_reset busy_done", {62'd0, Busy, Done}, 64'd0);
    mhi = '0; mlo = '0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) seen_done = 1'b1;
      if (Busy) seen_busy = 1'b1;
    end
    chk("midrun_reset no_done", {62'd0, seen_done, seen_busy}, 64'd0);
    chk("midrun_reset hilo_after", {Hi, Lo}, 64'd0);

    // Randomized operations with input noise while busy
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick(), 1, 0, "rand");
      if ($urandom_range(0, 3) == 0)
        mt(1'($urandom), 1'($urandom), $urandom, "rand_mt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
